// File: rtl/regbank_pkg.sv
// Shared register-bank constants, dump-reader state encoding and output word payload.
package regbank_pkg;

    localparam int unsigned REGISTER_LENGTH = 32;
    localparam int unsigned ADDR_WIDTH      = 4;
    localparam int unsigned CNT_WIDTH       = 4;

    localparam logic [ADDR_WIDTH-1:0] PC_REGISTER      = 4'd15;
    localparam logic [ADDR_WIDTH-1:0] SP_REGISTER      = 4'd14;
    localparam logic [ADDR_WIDTH-1:0] LR_REGISTER      = 4'd13;
    localparam logic [ADDR_WIDTH-1:0] SYSCALL_REGISTER = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } dump_state_t;

    typedef struct packed {
        logic                       last;
        logic [ADDR_WIDTH-1:0]      index;
        logic [REGISTER_LENGTH-1:0] data;
    } dump_word_t;

endpackage

// File: rtl/dump_delay_counter.sv
// Loadable down-counter with a zero flag; used for settle and read-latency waits.
module dump_delay_counter
    import regbank_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 dec,
    output logic                 zero_c
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/regbank_dump_reader.sv
// Debug reader: freezes the register bank, walks a wrapping index range through one
// read port and streams {index, value} words over a valid/ready handshake.
module regbank_dump_reader
    import regbank_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                       fast_clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_WIDTH-1:0]      first_reg,
    input  logic [ADDR_WIDTH-1:0]      last_reg,
    output logic                       bank_hold,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    input  logic [REGISTER_LENGTH-1:0] read_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_index,
    output logic [REGISTER_LENGTH-1:0] out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    dump_state_t           state, state_d;
    logic [ADDR_WIDTH-1:0] idx, idx_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] read_addr_d;
    dump_word_t            word_q, word_d;
    logic                  out_valid_d, bank_hold_d, busy_d, done_d;

    logic settle_load_c, settle_dec_c, settle_zero_c;
    logic lat_load_c, lat_dec_c, lat_zero_c;

    dump_delay_counter u_settle_cnt (
        .clk        (fast_clock),
        .reset      (reset),
        .load       (settle_load_c),
        .load_value (CNT_WIDTH'(SETTLE_CYCLES - 1)),
        .dec        (settle_dec_c),
        .zero_c     (settle_zero_c)
    );

    dump_delay_counter u_lat_cnt (
        .clk        (fast_clock),
        .reset      (reset),
        .load       (lat_load_c),
        .load_value (CNT_WIDTH'(READ_LATENCY - 1)),
        .dec        (lat_dec_c),
        .zero_c     (lat_zero_c)
    );

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        last_d        = last_q;
        read_addr_d   = read_addr;
        word_d        = word_q;
        out_valid_d   = out_valid;
        bank_hold_d   = bank_hold;
        busy_d        = busy;
        done_d        = 1'b0;
        settle_load_c = 1'b0;
        settle_dec_c  = 1'b0;
        lat_load_c    = 1'b0;
        lat_dec_c     = 1'b0;

        if ((state != ST_IDLE) && abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            bank_hold_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        idx_d         = first_reg;
                        last_d        = last_reg;
                        bank_hold_d   = 1'b1;
                        busy_d        = 1'b1;
                        settle_load_c = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (settle_zero_c) begin
                        read_addr_d = idx;
                        state_d     = ST_ISSUE;
                    end else begin
                        settle_dec_c = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    lat_load_c = 1'b1;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_zero_c) begin
                        word_d.data  = read_data;
                        word_d.index = idx;
                        word_d.last  = (idx == last_q);
                        out_valid_d  = 1'b1;
                        state_d      = ST_PRESENT;
                    end else begin
                        lat_dec_c = 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx == last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d       = idx + ADDR_WIDTH'(1);
                            read_addr_d = idx + ADDR_WIDTH'(1);
                            state_d     = ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    done_d      = 1'b1;
                    bank_hold_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    bank_hold_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            last_q    <= '0;
            read_addr <= '0;
            word_q    <= '0;
            out_valid <= 1'b0;
            bank_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            last_q    <= last_d;
            read_addr <= read_addr_d;
            word_q    <= word_d;
            out_valid <= out_valid_d;
            bank_hold <= bank_hold_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign out_index = word_q.index;
    assign out_data  = word_q.data;
    assign out_last  = word_q.last;

endmodule
